// File: rtl/cnt_seq_pkg.sv
// Shared types and default widths for the counter command sequencer.
package cnt_seq_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STEP_W = 16;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/cnt_seq_ctrl_props.sv
// Protocol assertions for cnt_seq_ctrl: ld/enb exclusivity and single-cycle done.
module cnt_seq_ctrl_props (
  input logic clk,
  input logic rst,
  input logic cnt_ld,
  input logic cnt_enb,
  input logic done
);

  a_ld_enb_excl: assert property (@(posedge clk) disable iff (rst) !(cnt_ld && cnt_enb));
  a_done_pulse:  assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Command sequencer owning the control pins of a 16-bit up/down counter.
// Optional saturation guard enabled by defining CNT_SEQ_SAT_EN.
module cnt_seq_ctrl
  import cnt_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_value,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt_data_in,
  output logic             cnt_ld,
  output logic             cnt_updn,
  output logic             cnt_enb,
  input  logic [WIDTH-1:0] cnt_data_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             aborted,
  output logic             sat
);

  state_e              state, state_nx;
  cmd_op_e             op;
  logic                accept;
  logic                sat_hit;
  logic [STEP_W-1:0]   steps;
  logic [STEP_W-1:0]   remaining;
  logic                dir_q;
  logic [WIDTH-1:0]    value_q;
  logic [WIDTH-1:0]    result_q;
  logic                aborted_q;

  assign op     = cmd_op_e'(cmd_op);
  assign steps  = STEP_W'(cmd_value);
  assign accept = cmd_valid && cmd_ready;

`ifdef CNT_SEQ_SAT_EN
  logic sat_q;
  // A step that would wrap is suppressed and ends the burst instead.
  assign sat_hit = (state == ST_RUN) && (dir_q ? (&cnt_data_out) : ~(|cnt_data_out));
  assign sat     = sat_q;
`else
  assign sat_hit = 1'b0;
  assign sat     = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    cnt_ld   = 1'b0;
    cnt_enb  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_LOAD:        state_nx = ST_LOAD;
            OP_UP, OP_DOWN: state_nx = (steps != '0) ? ST_RUN : ST_DONE;
            default:        state_nx = ST_DONE;
          endcase
        end
      end
      ST_LOAD: begin
        cnt_ld   = 1'b1;
        state_nx = ST_DONE;
      end
      ST_RUN: begin
        if (sat_hit) begin
          state_nx = ST_DONE;
        end else begin
          cnt_enb = 1'b1;
          if (remaining == STEP_W'(1) || abort) state_nx = ST_DONE;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      dir_q     <= 1'b1;
      value_q   <= '0;
      result_q  <= '0;
      aborted_q <= 1'b0;
`ifdef CNT_SEQ_SAT_EN
      sat_q     <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        aborted_q <= 1'b0;
`ifdef CNT_SEQ_SAT_EN
        sat_q     <= 1'b0;
`endif
        if (op == OP_LOAD) value_q <= cmd_value;
        // Direction only moves when a burst will actually run, so updn stays put otherwise.
        if ((op == OP_UP || op == OP_DOWN) && steps != '0) begin
          dir_q     <= (op == OP_UP);
          remaining <= steps;
        end
      end
      if (cnt_enb) begin
        remaining <= remaining - STEP_W'(1);
        if (abort) aborted_q <= 1'b1;
      end
`ifdef CNT_SEQ_SAT_EN
      if (sat_hit) sat_q <= 1'b1;
`endif
      if (state == ST_DONE) result_q <= cnt_data_out;
    end
  end

  assign cmd_ready   = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign cnt_updn    = dir_q;
  assign cnt_data_in = value_q;
  assign aborted     = aborted_q;
  // In DONE the counter already shows the final step, so result is live there and held after.
  assign result      = (state == ST_DONE) ? cnt_data_out : result_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Scoreboard bench for cnt_seq_ctrl with a behavioural counter on its control pins.
module tb_cnt_seq_ctrl;
  import cnt_seq_pkg::*;

`ifdef CNT_SEQ_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_value = '0;
  logic        abort = 1'b0;
  logic [15:0] cnt_data_in;
  logic        cnt_ld, cnt_updn, cnt_enb;
  logic [15:0] cnt_data_out = '0;
  logic        busy, done, aborted, sat;
  logic [15:0] result;

  typedef struct {
    logic [15:0] res;
    logic        ab;
    logic        st;
    int          enb;
    int          ld;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model = '0;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          enb_seen = 0;
  int          ld_seen  = 0;

  always #5 clk = ~clk;

  cnt_seq_ctrl #(.WIDTH(16), .STEP_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_value(cmd_value), .abort(abort),
    .cnt_data_in(cnt_data_in), .cnt_ld(cnt_ld), .cnt_updn(cnt_updn), .cnt_enb(cnt_enb),
    .cnt_data_out(cnt_data_out), .busy(busy), .done(done), .result(result),
    .aborted(aborted), .sat(sat)
  );

  bind cnt_seq_ctrl cnt_seq_ctrl_props u_props (
    .clk(clk), .rst(rst), .cnt_ld(cnt_ld), .cnt_enb(cnt_enb), .done(done)
  );

  // Behavioural counter: ld has priority, otherwise enb counts with wrap.
  always @(posedge clk) begin
    if (cnt_ld)       cnt_data_out <= cnt_data_in;
    else if (cnt_enb) cnt_data_out <= cnt_updn ? cnt_data_out + 16'd1 : cnt_data_out - 16'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: counts counter activity per command and scores each done.
  always @(negedge clk) begin
    if (rst) begin
      enb_seen = 0;
      ld_seen  = 0;
    end else begin
      if (cnt_enb) enb_seen++;
      if (cnt_ld)  ld_seen++;
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result",   32'(result),   32'(e.res));
          check("aborted",  32'(aborted),  32'(e.ab));
          check("sat",      32'(sat),      32'(e.st));
          check("enb_cnt",  32'(enb_seen), 32'(e.enb));
          check("ld_cnt",   32'(ld_seen),  32'(e.ld));
          check("ready_in_done", 32'(cmd_ready), 32'd0);
        end
        enb_seen = 0;
        ld_seen  = 0;
      end
    end
  end

  // Command-level reference model producing the expected completion record.
  function automatic void expect_cmd(input cmd_op_e op, input logic [15:0] v);
    exp_t        e;
    logic [15:0] room;
    int          n;
    e = '{res: 16'h0, ab: 1'b0, st: 1'b0, enb: 0, ld: 0};
    case (op)
      OP_LOAD: begin
        model = v;
        e.ld  = 1;
      end
      OP_UP, OP_DOWN: begin
        n    = int'(v);
        room = (op == OP_UP) ? 16'hFFFF - model : model;
        if (SAT_EN && n > int'(room)) begin
          n    = int'(room);
          e.st = 1'b1;
        end
        model = (op == OP_UP) ? model + 16'(n) : model - 16'(n);
        e.enb = n;
      end
      default: ;
    endcase
    e.res = model;
    sb.push_back(e);
  endfunction

  // Presents a command at a falling edge and returns #1 after the accepting edge; valid stays high.
  task automatic send(input cmd_op_e op, input logic [15:0] v);
    int guard = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_value = v;
    while (!cmd_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    cmd_valid = 1'b0;
    while (sb.size() != 0 && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    repeat (2) @(posedge clk);
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctl"}, {cmd_ready, busy, done, cnt_ld, cnt_enb, cnt_updn, aborted, sat},
          8'b1000_0100);
    check({tag, "_data"}, {cnt_data_in, result}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int k;
    int guard;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // LOAD with latency probe, then UP 5.
    expect_cmd(OP_LOAD, 16'h1234);
    send(OP_LOAD, 16'h1234);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("load_ld", {cnt_ld, done, cnt_data_in}, {2'b10, 16'h1234});
    @(negedge clk);
    check("load_done", {cnt_ld, done}, 2'b01);
    expect_cmd(OP_UP, 16'd5);
    send(OP_UP, 16'd5);
    drain();
    check("up5_hold", 32'(result), 32'h1239);

    // DOWN across zero: wraps or saturates.
    expect_cmd(OP_LOAD, 16'h0002);
    send(OP_LOAD, 16'h0002);
    expect_cmd(OP_DOWN, 16'd4);
    send(OP_DOWN, 16'd4);
    drain();
    check("down_result", {result, sat}, SAT_EN ? {16'h0000, 1'b1} : {16'hFFFE, 1'b0});

    // Zero-step UP and NOP complete in the cycle after acceptance.
    expect_cmd(OP_UP, 16'd0);
    send(OP_UP, 16'd0);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("up0_lat", {done, cnt_enb, cnt_ld}, 3'b100);
    expect_cmd(OP_NOP, 16'hABCD);
    send(OP_NOP, 16'hABCD);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("nop_lat", {done, cnt_enb, cnt_ld}, 3'b100);
    drain();

    // Abort on the 10th enabled edge of a 100-step burst.
    expect_cmd(OP_LOAD, 16'h0000);
    send(OP_LOAD, 16'h0000);
    drain();
    sb.push_back('{res: 16'h000A, ab: 1'b1, st: 1'b0, enb: 10, ld: 0});
    model = 16'h000A;
    send(OP_UP, 16'd100);
    cmd_valid = 1'b0;
    k = 0;
    guard = 0;
    while (k < 10 && guard < 200) begin
      @(negedge clk);
      if (cnt_enb) k++;
      guard++;
    end
    check("abort_reach", 32'(k), 32'd10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    drain();

    // Back-to-back commands with cmd_valid held high throughout.
    expect_cmd(OP_LOAD, 16'h00F0); send(OP_LOAD, 16'h00F0);
    expect_cmd(OP_UP,   16'd3);    send(OP_UP,   16'd3);
    expect_cmd(OP_DOWN, 16'd2);    send(OP_DOWN, 16'd2);
    expect_cmd(OP_NOP,  16'd7);    send(OP_NOP,  16'd7);
    expect_cmd(OP_UP,   16'd0);    send(OP_UP,   16'd0);
    expect_cmd(OP_LOAD, 16'h7FFF); send(OP_LOAD, 16'h7FFF);
    expect_cmd(OP_UP,   16'd1);    send(OP_UP,   16'd1);
    drain();
    check("b2b_final", 32'(result), 32'h8000);

    // Reset in the middle of a burst: no done, reset values, then normal operation.
    expect_cmd(OP_LOAD, 16'h0000);
    send(OP_LOAD, 16'h0000);
    drain();
    send(OP_UP, 16'd50);
    cmd_valid = 1'b0;
    k = 0;
    guard = 0;
    while (k < 20 && guard < 200) begin
      @(negedge clk);
      if (cnt_enb) k++;
      guard++;
    end
    check("rst_pre_enb", 32'(cnt_enb), 32'd1);
    #2 rst = 1'b1;
    #1 check("rst_async_enb", {cnt_enb, busy}, 2'b00);
    repeat (3) @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    expect_cmd(OP_LOAD, 16'hBEEF);
    send(OP_LOAD, 16'hBEEF);
    expect_cmd(OP_UP, 16'd3);
    send(OP_UP, 16'd3);
    drain();
    check("post_rst", 32'(result), 32'hBEF2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
